branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 105 ++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters and update statistics.
// Define BP_JUMP_EN to let J/JAL updates allocate strongly-taken entries.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_f,
    output logic             pred_taken_f,
    output logic [31:0]      pred_target_f,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_is_jump,
    input  logic             upd_pred_taken,
    input  logic [31:0]      upd_pred_target,
    output logic             upd_mispredict,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag    [ENTRIES];
    logic [29:0]        target [ENTRIES];
    logic [1:0]         cnt    [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             accept;
    logic             jump_wr;
    logic             wrong;
    logic [1:0]       cnt_inc;
    logic [1:0]       cnt_dec;

    assign f_idx = pc_f[IDX_W+1:2];
    assign f_tag = pc_f[31:IDX_W+2];
    assign f_hit = valid[f_idx] && (tag[f_idx] == f_tag);

    // Reset gating keeps the lookup quiet even before the first reset edge.
    assign pred_taken_f  = !reset && f_hit && cnt[f_idx][1];
    assign pred_target_f = pred_taken_f ? {target[f_idx], 2'b00} : 32'h0;

    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[31:IDX_W+2];
    assign u_hit = valid[u_idx] && (tag[u_idx] == u_tag);

`ifdef BP_JUMP_EN
    assign accept  = upd_valid;
    assign jump_wr = upd_is_jump;
`else
    assign accept  = upd_valid && !upd_is_jump;
    assign jump_wr = 1'b0;
`endif

    assign wrong = (upd_pred_taken != upd_taken) ||
                   (upd_taken && (upd_pred_target != upd_target));
    assign upd_mispredict = accept && wrong;

    assign cnt_inc = (cnt[u_idx] == 2'b11) ? 2'b11 : cnt[u_idx] + 2'd1;
    assign cnt_dec = (cnt[u_idx] == 2'b00) ? 2'b00 : cnt[u_idx] - 2'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
                cnt[i]   <= 2'b01;
            end
            br_count      <= '0;
            mispred_count <= '0;
        end else if (accept) begin
            if (!(&br_count))
                br_count <= br_count + 1'b1;
            if (upd_mispredict && !(&mispred_count))
                mispred_count <= mispred_count + 1'b1;
            if (jump_wr) begin
                valid[u_idx]  <= 1'b1;
                tag[u_idx]    <= u_tag;
                target[u_idx] <= upd_target[31:2];
                cnt[u_idx]    <= 2'b11;
            end else if (u_hit) begin
                if (upd_taken) begin
                    cnt[u_idx]    <= cnt_inc;
                    target[u_idx] <= upd_target[31:2];
                end else begin
                    cnt[u_idx] <= cnt_dec;
                end
            end else if (upd_taken) begin
                valid[u_idx]  <= 1'b1;
                tag[u_idx]    <= u_tag;
                target[u_idx] <= upd_target[31:2];
                cnt[u_idx]    <= 2'b10;
            end
        end
    end

endmodule
